// File: rtl/debug_pkg.sv
// Shared types and constants for the CPU debug console.
// Holds the read FSM state set and the display selector codes.
package debug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } rd_state_t;

    localparam logic [2:0] STYPE_SYS  = 3'd0;
    localparam logic [2:0] STYPE_CYC  = 3'd1;
    localparam logic [2:0] STYPE_UNCB = 3'd2;
    localparam logic [2:0] STYPE_CB   = 3'd3;
    localparam logic [2:0] STYPE_MEM  = 3'd4;

    localparam int NUM_MODES = 5;

endpackage

// File: rtl/cpu_debug_console_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debouncer and
// rising-edge detector producing a one-cycle event per accepted press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            level_q <= level;
            // any sample agreeing with the accepted level restarts the count
            if (s2 != level) begin
                if (cnt == LAST) begin
                    level <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign ev = level & ~level_q;

endmodule

// File: rtl/cpu_debug_console.sv
// Debug front end for SingleCycleCPU: button events, display-mode stepping
// and interrupt-gated data memory reads for the seven-segment display.
module cpu_debug_console
    import debug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_go,
    input  logic              btn_mode,
    input  logic              btn_next,
    input  logic              halt,
    input  logic [31:0]       led_data,
    output logic              go,
    output logic [2:0]        s_type,
    output logic              interupt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       disp_data,
    output logic              disp_valid,
    output logic              busy
);

    localparam logic [2:0] LAST_MODE = 3'(NUM_MODES - 1);

    logic go_ev;
    logic mode_ev;
    logic next_ev;

    rd_state_t         state;
    rd_state_t         state_n;
    logic [2:0]        s_type_n;
    logic [ADDR_W-1:0] addr_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go (
        .clk (clk),
        .rst (rst),
        .btn (btn_go),
        .ev  (go_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk (clk),
        .rst (rst),
        .btn (btn_mode),
        .ev  (mode_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk (clk),
        .rst (rst),
        .btn (btn_next),
        .ev  (next_ev)
    );

    // mode_ev has priority; both are ignored unless the FSM is idle
    always_comb begin
        state_n  = state;
        s_type_n = s_type;
        addr_n   = mem_addr;
        unique case (state)
            IDLE: begin
                if (mode_ev) begin
                    s_type_n = (s_type == LAST_MODE) ? STYPE_SYS
                                                     : s_type + 3'd1;
                    if (s_type_n == STYPE_MEM) begin
                        state_n = REQ;
                    end
                end else if (next_ev && (s_type == STYPE_MEM)) begin
                    addr_n  = mem_addr + ADDR_W'(1);
                    state_n = REQ;
                end
            end
            REQ:     state_n = WAIT;
            WAIT:    state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_type    <= STYPE_SYS;
            mem_addr  <= '0;
            go        <= 1'b0;
            disp_data <= '0;
        end else begin
            state    <= state_n;
            s_type   <= s_type_n;
            mem_addr <= addr_n;
            go       <= go_ev & halt;
            // memory mode holds the last read word between reads
            if ((state == WAIT) || (s_type != STYPE_MEM)) begin
                disp_data <= led_data;
            end
        end
    end

    assign interupt   = (state == REQ) || (state == WAIT);
    assign disp_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cpu_debug_console.sv
// Self-checking bench for cpu_debug_console with a small CPU memory model
// and a scoreboard of expected words for each memory read.
module tb_cpu_debug_console;

    localparam int D  = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_go;
    logic          btn_mode;
    logic          btn_next;
    logic          halt;
    logic [31:0]   led_data;
    logic          go;
    logic [2:0]    s_type;
    logic          interupt;
    logic [AW-1:0] mem_addr;
    logic [31:0]   disp_data;
    logic          disp_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];
    int run      = 0;
    int last_run = 0;
    int m_stype  = 0;
    int m_addr   = 0;

    cpu_debug_console #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_go     (btn_go),
        .btn_mode   (btn_mode),
        .btn_next   (btn_next),
        .halt       (halt),
        .led_data   (led_data),
        .go         (go),
        .s_type     (s_type),
        .interupt   (interupt),
        .mem_addr   (mem_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // CPU model: RAM word appears on led_data one cycle after interupt
    always @(posedge clk) begin
        if (interupt) led_data <= 32'hDEAD0000 + 32'(mem_addr);
        else          led_data <= 32'hCAFE0000;
    end

    always @(negedge clk) begin
        if (interupt) begin
            run = run + 1;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (disp_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_disp_valid got=%h want=none", disp_data);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (disp_data !== exp) begin
                    bad++;
                    $display("FAIL read_data got=%h want=%h", disp_data, exp);
                end
                total++;
                if (last_run !== 2) begin
                    bad++;
                    $display("FAIL interupt_len got=%0d want=2", last_run);
                end
            end
        end
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_go = v;
            1: btn_mode = v;
            default: btn_next = v;
        endcase
    endtask

    task automatic press(input int which);
        if (which == 1) begin
            m_stype = (m_stype + 1) % 5;
            if (m_stype == 4) sb.push_back(32'hDEAD0000 + 32'(m_addr));
        end else if (which == 2 && m_stype == 4) begin
            m_addr = (m_addr + 1) % 1024;
            sb.push_back(32'hDEAD0000 + 32'(m_addr));
        end
        @(negedge clk) set_btn(which, 1'b1);
        repeat (8) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (8) @(negedge clk);
        total += 2;
        if (s_type !== 3'(m_stype)) begin
            bad++;
            $display("FAIL press_s_type got=%0d want=%0d", s_type, m_stype);
        end
        if (mem_addr !== AW'(m_addr)) begin
            bad++;
            $display("FAIL press_addr got=%0d want=%0d", mem_addr, m_addr);
        end
    endtask

    task automatic test_reset();
        int gcnt;
        rst = 1'b1;
        halt = 1'b1;
        btn_go = 1'b1;
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (2) @(negedge clk);
        total += 4;
        if (go !== 1'b0 || disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_go_valid got=%b%b want=00", go, disp_valid);
        end
        if (s_type !== 3'd0 || mem_addr !== '0) begin
            bad++;
            $display("FAIL reset_mode_addr got=%0d/%0d want=0/0", s_type, mem_addr);
        end
        if (interupt !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_int_busy got=%b%b want=00", interupt, busy);
        end
        if (disp_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_disp got=%h want=0", disp_data);
        end
        rst = 1'b0;
        btn_go = 1'b0;
        gcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (go) gcnt++;
        end
        total++;
        if (gcnt !== 0) begin
            bad++;
            $display("FAIL reset_btn_go got=%0d want=0", gcnt);
        end
    endtask

    task automatic test_resume();
        int gcnt;
        int at;
        halt = 1'b1;
        @(negedge clk) btn_go = 1'b1;
        gcnt = 0;
        at = -1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (go) begin
                gcnt++;
                at = j;
            end
        end
        btn_go = 1'b0;
        repeat (10) @(negedge clk);
        total += 2;
        if (gcnt !== 1) begin
            bad++;
            $display("FAIL resume_count got=%0d want=1", gcnt);
        end
        if (at !== 6) begin
            bad++;
            $display("FAIL resume_latency got=%0d want=6", at);
        end
        halt = 1'b0;
        @(negedge clk) btn_go = 1'b1;
        gcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (go) gcnt++;
        end
        btn_go = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (gcnt !== 0) begin
            bad++;
            $display("FAIL resume_not_halted got=%0d want=0", gcnt);
        end
    endtask

    task automatic test_bounce();
        logic [2:0] prev;
        int chg;
        logic [4:0] pat;
        pat = 5'b10101;
        prev = s_type;
        chg = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk) btn_mode = pat[j];
            if (s_type !== prev) chg++;
            prev = s_type;
        end
        repeat (16) begin
            @(negedge clk);
            if (s_type !== prev) chg++;
            prev = s_type;
        end
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        m_stype = 1;
        total += 4;
        if (chg !== 1) begin
            bad++;
            $display("FAIL bounce_events got=%0d want=1", chg);
        end
        if (s_type !== 3'd1) begin
            bad++;
            $display("FAIL bounce_s_type got=%0d want=1", s_type);
        end
        if (disp_data !== 32'hCAFE0000) begin
            bad++;
            $display("FAIL mode1_disp got=%h want=cafe0000", disp_data);
        end
        if (disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mode1_valid got=%b want=0", disp_valid);
        end
        press(2);
    endtask

    task automatic test_memory();
        repeat (3) press(1);
        total++;
        if (disp_data !== 32'hDEAD0000) begin
            bad++;
            $display("FAIL mem_first got=%h want=dead0000", disp_data);
        end
        press(2);
        total++;
        if (disp_data !== 32'hDEAD0001) begin
            bad++;
            $display("FAIL mem_next got=%h want=dead0001", disp_data);
        end
    endtask

    task automatic test_wrap_arb();
        while (m_addr != 1023) press(2);
        press(2);
        total++;
        if (disp_data !== 32'hDEAD0000) begin
            bad++;
            $display("FAIL wrap_disp got=%h want=dead0000", disp_data);
        end
        @(negedge clk);
        btn_mode = 1'b1;
        btn_next = 1'b1;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (8) @(negedge clk);
        m_stype = 0;
        total += 3;
        if (s_type !== 3'd0) begin
            bad++;
            $display("FAIL arb_s_type got=%0d want=0", s_type);
        end
        if (mem_addr !== AW'(m_addr)) begin
            bad++;
            $display("FAIL arb_addr got=%0d want=%0d", mem_addr, m_addr);
        end
        if (disp_data !== 32'hCAFE0000) begin
            bad++;
            $display("FAIL mode0_disp got=%h want=cafe0000", disp_data);
        end
        repeat (3) press(1);
        m_stype = 4;
        sb.push_back(32'hDEAD0000 + 32'(m_addr));
        @(negedge clk) btn_mode = 1'b1;
        @(negedge clk) btn_next = 1'b1;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0;
        btn_next = 1'b0;
        repeat (8) @(negedge clk);
        total += 2;
        if (mem_addr !== AW'(m_addr)) begin
            bad++;
            $display("FAIL busy_drop_addr got=%0d want=%0d", mem_addr, m_addr);
        end
        if (s_type !== 3'd4) begin
            bad++;
            $display("FAIL busy_s_type got=%0d want=4", s_type);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk) btn_next = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (interupt !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midread_wait got=%b%b want=11", interupt, busy);
        end
        rst = 1'b1;
        btn_next = 1'b0;
        @(negedge clk);
        total += 3;
        if (interupt !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midread_int_busy got=%b%b want=00", interupt, busy);
        end
        if (s_type !== 3'd0) begin
            bad++;
            $display("FAIL midread_s_type got=%0d want=0", s_type);
        end
        if (disp_valid !== 1'b0) begin
            bad++;
            $display("FAIL midread_valid got=%b want=0", disp_valid);
        end
        rst = 1'b0;
        m_stype = 0;
        m_addr = 0;
        repeat (12) @(negedge clk);
        total++;
        if (mem_addr !== '0) begin
            bad++;
            $display("FAIL midread_addr got=%0d want=0", mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_resume();
        test_bounce();
        test_memory();
        test_wrap_arb();
        test_reset_mid_read();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL reads_missing got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
